// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO.
// Bytes are pushed with a valid/ready handshake and sent back to back, LSB first.
// Every output is registered except in_ready, which decodes the registered count.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   in_Byte,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         serial_out,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(FIFO_DEPTH):0]  o_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE   = BW'(CLKS_PER_BIT - 2);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_serial;
    logic            r_busy;
    logic            r_done;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_baud_end;

    assign in_ready   = (r_count != COUNT_FULL);
    assign w_push     = in_valid && in_ready;
    assign w_baud_end = (r_baud == BAUD_LAST);
    // Pop when idle, or on the last stop-bit cycle so the next start bit follows without a gap.
    assign w_pop      = (r_count != '0) &&
                        ((r_state == StIdle) || ((r_state == StStop) && w_baud_end));

    assign serial_out = r_serial;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_count    = r_count;

    // Buffer storage; contents are meaningless once the pointers are cleared, so no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_Byte;
        end
    end

    // Buffer pointers and occupancy; push and pop on the same edge both take effect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer: start, eight data bits, stop; line, busy and done are registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_serial <= 1'b1;
                    r_baud   <= '0;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_bit    <= '0;
                        r_state  <= StStart;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                StStart: begin
                    if (w_baud_end) begin
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_state  <= StData;
                        r_serial <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                StData: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state  <= StStop;
                            r_serial <= 1'b1;
                        end else begin
                            r_bit    <= r_bit + 3'd1;
                            r_serial <= r_shift[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                StStop: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift  <= r_mem[r_rd_ptr];
                            r_bit    <= '0;
                            r_state  <= StStart;
                            r_serial <= 1'b0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        // Registered pulse lands on the final stop-bit cycle.
                        if (r_baud == BAUD_PRE) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
